// File: rtl/sfr_bank_intr.sv
`default_nettype none
// ============================================================================
// Module   : sfr_bank_intr
// Brief    : SFR bank with CTRL, W1C interrupt status, mask, masked status and
//            version registers. Byte-strobed writes, hardware event capture,
//            error responses for illegal accesses, and a registered irq line.
// Revision : 1.0 - initial release
// ============================================================================
module sfr_bank_intr #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 NUM_CH   = 8,
  parameter int                 EDGE_DET = 1,
  parameter logic [DATA_W-1:0]  CTRL_RST = 'h5,
  parameter logic [NUM_CH-1:0]  MSK_RST  = 'h1,
  parameter logic [DATA_W-1:0]  VERSION  = 'h0002_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [ADDR_W-1:0]     i_raddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrobe,
  input  logic [NUM_CH-1:0]     i_intr_evt,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_wready,
  output logic                  o_rvalid,
  output logic                  o_err,
  output logic                  o_irq
);

  localparam int NUM_LANES = DATA_W / 8;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] A_STS    = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] A_MSK    = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] A_MASKED = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] A_VER    = ADDR_W'('h10);

  // Architectural state
  logic [DATA_W-1:0] ctrl;
  logic [NUM_CH-1:0] sts;
  logic [NUM_CH-1:0] msk;
  logic [NUM_CH-1:0] evt_q;

  // Registered response state
  logic              wready_q;
  logic              rvalid_q;
  logic              err_q;
  logic              irq_q;
  logic [DATA_W-1:0] rdata_q;

  // Next-state and decode
  logic [DATA_W-1:0] wmask;
  logic              wr_ctrl, wr_sts, wr_msk, wr_err;
  logic [DATA_W-1:0] ctrl_nx;
  logic [NUM_CH-1:0] msk_nx, sts_clr, sts_set, sts_nx;
  logic [DATA_W-1:0] sts_ext, masked_ext, rd_val;
  logic              rd_err;

  // Expand byte strobes into a bit mask
  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign wmask[8*k +: 8] = {8{i_wstrobe[k]}};
    end
  endgenerate

  // Write decode: only CTRL, STS and MSK accept writes; all else errors
  always_comb begin
    wr_ctrl = i_wr_en && (i_waddr == A_CTRL);
    wr_sts  = i_wr_en && (i_waddr == A_STS);
    wr_msk  = i_wr_en && (i_waddr == A_MSK);
    wr_err  = i_wr_en && !(wr_ctrl || wr_sts || wr_msk);
  end

  // Register next-state: byte-lane merge, W1C clear, event set (set wins)
  always_comb begin
    ctrl_nx = wr_ctrl ? ((ctrl & ~wmask) | (i_wdata & wmask)) : ctrl;
    msk_nx  = msk;
    sts_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_msk && wmask[i]) msk_nx[i] = i_wdata[i];
      sts_clr[i] = wr_sts && wmask[i] && i_wdata[i];
    end
    sts_set = (EDGE_DET != 0) ? (i_intr_evt & ~evt_q) : i_intr_evt;
    sts_nx  = (sts & ~sts_clr) | sts_set;
  end

  // Read mux with zero-extended narrow registers; unmapped addresses error
  always_comb begin
    sts_ext                  = '0;
    sts_ext[NUM_CH-1:0]      = sts;
    masked_ext               = '0;
    masked_ext[NUM_CH-1:0]   = sts & msk;
    rd_val                   = '0;
    rd_err                   = 1'b0;
    case (i_raddr)
      A_CTRL:   rd_val = ctrl;
      A_STS:    rd_val = sts_ext;
      A_MSK:    rd_val = {{(DATA_W-NUM_CH){1'b0}}, msk} | '0;
      A_MASKED: rd_val = masked_ext;
      A_VER:    rd_val = VERSION;
      default:  rd_err = 1'b1;
    endcase
  end

  // State and response registers; reads see pre-write register values
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= CTRL_RST;
      sts      <= '0;
      msk      <= MSK_RST;
      evt_q    <= '0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ctrl     <= ctrl_nx;
      sts      <= sts_nx;
      msk      <= msk_nx;
      evt_q    <= i_intr_evt;
      wready_q <= i_wr_en;
      rvalid_q <= i_rd_en;
      err_q    <= wr_err || (i_rd_en && rd_err);
      irq_q    <= ctrl[0] & (|(sts & msk));
      if (i_rd_en) rdata_q <= rd_err ? '0 : rd_val;
    end
  end

  // Reset masks any response already registered for the following cycle
  assign o_wready = wready_q & ~reset;
  assign o_rvalid = rvalid_q & ~reset;
  assign o_err    = err_q & ~reset;
  assign o_irq    = irq_q & ~reset;
  assign o_rdata  = reset ? '0 : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sfr_bank_intr.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfr_bank_intr
// Brief    : Directed self-checking bench for sfr_bank_intr (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfr_bank_intr;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rd_en;
  logic [31:0] waddr, raddr, wdata;
  logic [3:0]  wstrobe;
  logic [7:0]  intr_evt;
  logic [31:0] rdata;
  logic        wready, rvalid, err, irq;

  int checks   = 0;
  int failures = 0;

  sfr_bank_intr dut (
    .clk(clk), .reset(reset),
    .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_waddr(waddr), .i_raddr(raddr),
    .i_wdata(wdata), .i_wstrobe(wstrobe),
    .i_intr_evt(intr_evt),
    .o_rdata(rdata), .o_wready(wready), .o_rvalid(rvalid),
    .o_err(err), .o_irq(irq)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Single write; returns the response observed in the following cycle
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic ack, output logic e);
    wr_en = 1'b1; waddr = a; wdata = d; wstrobe = s;
    cyc();
    wr_en = 1'b0; wstrobe = 4'h0;
    ack = wready; e = err;
  endtask

  // Single read; returns the response observed in the following cycle
  task automatic bus_rd(input logic [31:0] a, output logic vld, output logic e,
                        output logic [31:0] d);
    rd_en = 1'b1; raddr = a;
    cyc();
    rd_en = 1'b0;
    vld = rvalid; e = err; d = rdata;
  endtask

  task automatic test_reset();
    logic v, e; logic [31:0] d;
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];
    addrs = '{32'h0, 32'h4, 32'h8, 32'h10};
    exps  = '{32'h5, 32'h0, 32'h1, 32'h0002_0000};
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if ({wready, rvalid, err, irq} !== 4'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%h exp=0000/0", {wready, rvalid, err, irq}, rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_rd(addrs[i], v, e, d);
      checks++;
      if (v !== 1'b1 || e !== 1'b0 || d !== exps[i]) begin
        failures++;
        $display("FAIL reset_read a=%h got v=%b e=%b d=%h exp v=1 e=0 d=%h", addrs[i], v, e, d, exps[i]);
      end
    end
    cyc();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0002_0000) begin
      failures++;
      $display("FAIL rdata_hold got v=%b d=%h exp v=0 d=00020000", rvalid, rdata);
    end
  endtask

  task automatic test_strobe();
    logic a, e, v; logic [31:0] d;
    bus_wr(32'h0, 32'hAABB_CCDD, 4'b0101, a, e);
    checks++;
    if (a !== 1'b1 || e !== 1'b0) begin
      failures++;
      $display("FAIL strobe_wack got a=%b e=%b exp a=1 e=0", a, e);
    end
    cyc();
    checks++;
    if (wready !== 1'b0) begin
      failures++;
      $display("FAIL wready_pulse got=%b exp=0", wready);
    end
    bus_rd(32'h0, v, e, d);
    checks++;
    if (d !== 32'h00BB_00DD) begin
      failures++;
      $display("FAIL strobe_ctrl got=%h exp=00bb00dd", d);
    end
    bus_wr(32'h8, 32'hFFFF_FFFF, 4'b0000, a, e);
    checks++;
    if (a !== 1'b1 || e !== 1'b0) begin
      failures++;
      $display("FAIL zero_strobe_ack got a=%b e=%b exp a=1 e=0", a, e);
    end
    bus_rd(32'h8, v, e, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL zero_strobe_msk got=%h exp=1", d);
    end
  endtask

  task automatic test_irq();
    logic a, e, v; logic [31:0] d;
    intr_evt = 8'h01;
    cyc();                      // edge N samples the event; STS set now
    intr_evt = 8'h00;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_early got=%b exp=0", irq);
    end
    cyc();
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_assert got=%b exp=1", irq);
    end
    bus_rd(32'hC, v, e, d);
    checks++;
    if (d !== 32'h1 || e !== 1'b0) begin
      failures++;
      $display("FAIL masked_read got d=%h e=%b exp d=1 e=0", d, e);
    end
    bus_wr(32'h4, 32'h1, 4'hF, a, e);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_lag got=%b exp=1", irq);
    end
    cyc();
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got=%b exp=0", irq);
    end
    bus_rd(32'h4, v, e, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL sts_clear got=%h exp=0", d);
    end
  endtask

  task automatic test_edge();
    logic a, e, v; logic [31:0] d;
    intr_evt = 8'h08;
    cyc();                                  // rising edge sets STS[3]
    bus_wr(32'h4, 32'h8, 4'hF, a, e);       // W1C while level still high
    cyc(); cyc(); cyc();
    intr_evt = 8'h00;
    bus_rd(32'h4, v, e, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL edge_hold_cleared got=%h exp=0", d);
    end
    intr_evt = 8'h08;                       // rising edge coincident with W1C
    bus_wr(32'h4, 32'h8, 4'hF, a, e);
    intr_evt = 8'h00;
    bus_rd(32'h4, v, e, d);
    checks++;
    if (d !== 32'h8) begin
      failures++;
      $display("FAIL set_wins got=%h exp=8", d);
    end
    bus_wr(32'h4, 32'h8, 4'hF, a, e);
    bus_rd(32'h4, v, e, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL edge_final_clear got=%h exp=0", d);
    end
  endtask

  task automatic test_err();
    logic a, e, v; logic [31:0] d;
    logic [31:0] bad_w [4];
    bad_w = '{32'h14, 32'h10, 32'hC, 32'h1};
    for (int i = 0; i < 4; i++) begin
      bus_wr(bad_w[i], 32'hFFFF_FFFF, 4'hF, a, e);
      checks++;
      if (a !== 1'b1 || e !== 1'b1) begin
        failures++;
        $display("FAIL err_write a=%h got a=%b e=%b exp a=1 e=1", bad_w[i], a, e);
      end
    end
    bus_rd(32'h2, v, e, d);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL err_read got v=%b e=%b d=%h exp v=1 e=1 d=0", v, e, d);
    end
    bus_rd(32'h0, v, e, d);
    checks++;
    if (d !== 32'h00BB_00DD || e !== 1'b0) begin
      failures++;
      $display("FAIL err_ctrl_kept got d=%h e=%b exp d=00bb00dd e=0", d, e);
    end
    bus_rd(32'h8, v, e, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL err_msk_kept got=%h exp=1", d);
    end
  endtask

  task automatic test_back_to_back();
    logic v, e; logic [31:0] d;
    wr_en = 1'b1; waddr = 32'h8; wdata = 32'h3; wstrobe = 4'hF;
    cyc();
    checks++;
    if (wready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got=%b exp=1", wready);
    end
    wdata = 32'h1;
    cyc();
    checks++;
    if (wready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got=%b exp=1", wready);
    end
    // Simultaneous write and read of MSK: read sees pre-write value
    wdata = 32'h7; rd_en = 1'b1; raddr = 32'h8;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0; wstrobe = 4'h0;
    checks++;
    if (wready !== 1'b1 || rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h1) begin
      failures++;
      $display("FAIL same_cycle got w=%b r=%b e=%b d=%h exp w=1 r=1 e=0 d=1", wready, rvalid, err, rdata);
    end
    bus_rd(32'h8, v, e, d);
    checks++;
    if (d !== 32'h7) begin
      failures++;
      $display("FAIL same_cycle_after got=%h exp=7", d);
    end
    // Bad write with good read: error is the OR of both
    wr_en = 1'b1; waddr = 32'h10; wdata = 32'h0; wstrobe = 4'hF;
    rd_en = 1'b1; raddr = 32'h0;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0; wstrobe = 4'h0;
    checks++;
    if (err !== 1'b1 || rdata !== 32'h00BB_00DD) begin
      failures++;
      $display("FAIL err_or got e=%b d=%h exp e=1 d=00bb00dd", err, rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic v, e; logic [31:0] d;
    wr_en = 1'b1; waddr = 32'h0; wdata = 32'h0; wstrobe = 4'hF;
    rd_en = 1'b1; raddr = 32'h8;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0; wstrobe = 4'h0;
    reset = 1'b1;
    #1;
    checks++;
    if ({wready, rvalid, err, irq} !== 4'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_suppress got=%b/%h exp=0000/0", {wready, rvalid, err, irq}, rdata);
    end
    cyc();
    reset = 1'b0;
    checks++;
    if ({wready, rvalid, err, irq} !== 4'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_after got=%b/%h exp=0000/0", {wready, rvalid, err, irq}, rdata);
    end
    bus_rd(32'h0, v, e, d);
    checks++;
    if (d !== 32'h5) begin
      failures++;
      $display("FAIL reset_ctrl_value got=%h exp=5", d);
    end
    bus_rd(32'h8, v, e, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL reset_msk_value got=%h exp=1", d);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wstrobe = '0; intr_evt = '0;
    test_reset();
    test_strobe();
    test_irq();
    test_edge();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfr_bank_intr.md
Name: sfr_bank_intr

Overview:
- Parametrised special-function-register bank: control, interrupt status, interrupt mask, masked-status and version registers.
- Byte-strobed writes, write-1-to-clear interrupt status, hardware interrupt event capture, and an error response for illegal accesses.
- Drives a registered interrupt line to the system.
- Sits on the same simple wr/rd register port as the existing SFR blocks, between the bus adapter and the peripheral core.

Parameters:
- DATA_W, 32, register/data width; multiple of 8.
- ADDR_W, 32, address width.
- NUM_CH, 8, interrupt channels (1..DATA_W).
- EDGE_DET, 1, 1 = rising edge of i_intr_evt sets status; 0 = high level sets status every cycle.
- CTRL_RST, 'h5, CTRL reset value.
- MSK_RST, 'h1, INTR_MSK reset value.
- VERSION, 'h0002_0000, VERSION register constant.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_wr_en  in  1  write request, one transfer per cycle high.
- i_rd_en  in  1  read request.
- i_waddr  in  ADDR_W  write byte address.
- i_raddr  in  ADDR_W  read byte address.
- i_wdata  in  DATA_W  write data.
- i_wstrobe  in  DATA_W/8  byte-lane enables.
- i_intr_evt  in  NUM_CH  hardware interrupt events.
- o_rdata  out  DATA_W  read data.
- o_wready  out  1  write acknowledge pulse.
- o_rvalid  out  1  read data valid pulse.
- o_err  out  1  access error, qualifies o_wready/o_rvalid.
- o_irq  out  1  interrupt request.

Behaviour:
- Reset (sync, high):
  - CTRL=CTRL_RST; INTR_STS=0; INTR_MSK=MSK_RST; event history=0.
  - All outputs 0, including o_rdata.
  - Any response due in the cycle after reset is suppressed. Reset overrides every other event.
- Register map (byte addresses):
  - 0x0 CTRL: RW.
  - 0x4 INTR_STS: W1C.
  - 0x8 INTR_MSK: RW.
  - 0xC INTR_MASKED: RO, reads STS & MSK.
  - 0x10 VERSION: RO.
- Width rules: STS and MSK implement bits [NUM_CH-1:0] only. Upper bits read 0 and ignore writes.
- Write, latency 1:
  - i_wr_en high at cycle N gives o_wready=1 at N+1 for exactly 1 cycle.
  - Back-to-back writes give continuous o_wready.
  - For each byte lane k with i_wstrobe[k]=1, that byte updates (RW) or its 1-bits clear STS (W1C).
  - i_wstrobe=0 gives ack with no update and no error.
- Read, latency 1:
  - i_rd_en high at cycle N gives o_rvalid=1 and o_rdata at N+1.
  - o_rdata holds its last value while o_rvalid=0.
- Simultaneous i_wr_en and i_rd_en: both are accepted. The read returns the pre-write value, and o_wready and o_rvalid pulse together.
- Error (o_err=1 with the matching ack, for 1 cycle):
  - Triggers: address not in map, address[1:0]!=0, or write to 0xC/0x10.
  - Errored write changes nothing; errored read returns o_rdata=0.
  - When both a write and a read complete in the same cycle, o_err = OR of both errors.
- Interrupt capture:
  - EDGE_DET=1: STS[i] sets when i_intr_evt[i]=1 and the previous-cycle sample was 0.
  - EDGE_DET=0: STS[i] sets whenever i_intr_evt[i]=1.
  - Set and W1C clear on the same bit in the same cycle: set wins.
  - Events are captured regardless of MSK.
- o_irq = CTRL[0] & |(STS & MSK), registered, so it follows the register state by 1 cycle.
  - Example: event at N, STS set at N+1, o_irq at N+2.
  - Clearing STS or MSK, or CTRL[0]=0, deasserts o_irq one cycle after the register update.

Test Plan:
1. Reset then read 0x0, 0x4, 0x8, 0x10 -> o_rdata 'h5, 0, 'h1, 'h0002_0000; o_rvalid one cycle after each i_rd_en; o_err=0.
2. Write 0x0 data 'hAABBCCDD, strobe 4'b0101, then read 0x0 -> o_rdata 'h00BB00DD (reset bits outside written lanes kept: 'h5 replaced in lane 0 -> 'h00BB00DD); o_wready one cycle pulse.
3. MSK='h1, CTRL[0]=1, pulse i_intr_evt[0] at cycle N -> STS='h1 at N+1, o_irq=1 at N+2. Write 'h1 to 0x4 -> STS=0 and o_irq=0 two cycles after the write.
4. Hold i_intr_evt[3]=1 for 5 cycles (EDGE_DET=1) while writing 'h8 to 0x4 on the second cycle -> STS[3] cleared and not re-set. Repeat with a rising edge coincident with the W1C -> STS[3] stays 1.
5. Write 0x14, write 0x10, read 0x2 -> o_err=1 with each ack; read data 0; registers unchanged.
6. Same-cycle write 'h7 to 0x8 and read 0x8 -> o_rvalid and o_wready together, o_rdata='h1; next read returns 'h7. Assert reset the cycle after a request -> no ack, all outputs 0.
